// File: rtl/static_pin_test_sequencer_if.sv
// static_pin_test_sequencer_if: AXI4-Lite link between the pin test sequencer
// and the static_pin_tester slave it drives.
interface static_pin_test_sequencer_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/static_pin_test_sequencer.sv
// static_pin_test_sequencer: AXI4-Lite initiator that drives each pin low then high,
// releases it, reads it back and classifies it as tied-high, tied-low, floating or anomalous.
module static_pin_test_sequencer #(
    parameter int WIDTH              = 1,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 11,
    parameter int BASE_ADDR          = 0,
    parameter int SETTLE_CYCLES      = 100000,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] tied_high,
    output logic [WIDTH-1:0] tied_low,
    output logic [WIDTH-1:0] floating,
    output logic [WIDTH-1:0] anomalous,
    static_pin_test_sequencer_if.master m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [DW-1:0] ONES = DW'((64'd1 << WIDTH) - 64'd1);

    // Declaration order is the run order, so a successful step simply advances by one.
    typedef enum logic [3:0] {
        IDLE, RD_W, WD0, WT0, SET0, WT1, RV0, WD1, WTA, SET1, WTB, RV1, CLASS, FIN
    } state_t;

    state_t           state;
    state_t           nxt;
    logic             act;
    logic [31:0]      tmo;
    logic [31:0]      cnt;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             b_hs;
    logic             r_hs;
    logic             phase_end;
    logic             resp_bad;
    logic             is_wr;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdat;

    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;
    assign m_axi.wstrb  = 4'hF;

    assign nxt   = state_t'(state + 4'd1);
    assign aw_hs = m_axi.awvalid & m_axi.awready;
    assign w_hs  = m_axi.wvalid & m_axi.wready;
    assign ar_hs = m_axi.arvalid & m_axi.arready;
    assign b_hs  = m_axi.bvalid & m_axi.bready;
    assign r_hs  = m_axi.rvalid & m_axi.rready;

    // The request phase ends once every raised VALID has been accepted; the response
    // phase then gets a fresh timeout budget.
    assign phase_end = (m_axi.awvalid | m_axi.wvalid | m_axi.arvalid)
                     & ~(m_axi.awvalid & ~m_axi.awready)
                     & ~(m_axi.wvalid & ~m_axi.wready)
                     & ~(m_axi.arvalid & ~m_axi.arready);

    assign is_wr = state inside {WD0, WT0, WT1, WD1, WTA, WTB};
    assign addr  = AW'(BASE_ADDR + ((state == RD_W) ? 12 :
                                    (state == RV0 || state == RV1) ? 8 :
                                    (state == WD0 || state == WD1) ? 0 : 4));
    assign wdat  = (state inside {WT1, WD1, WTB}) ? ONES : '0;

    assign resp_bad = b_hs ? (m_axi.bresp != 2'b00)
                           : (m_axi.rresp != 2'b00 ||
                              (state == RD_W && m_axi.rdata != DW'(WIDTH)));

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state         <= IDLE;
            act           <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            tied_high     <= '0;
            tied_low      <= '0;
            floating      <= '0;
            anomalous     <= '0;
            r0            <= '0;
            r1            <= '0;
            tmo           <= '0;
            cnt           <= '0;
            m_axi.awaddr  <= '0;
            m_axi.wdata   <= '0;
            m_axi.araddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        tied_high <= '0;
                        tied_low  <= '0;
                        floating  <= '0;
                        anomalous <= '0;
                        act       <= 1'b0;
                        state     <= RD_W;
                    end
                end
                SET0, SET1: begin
                    if (cnt == '0)
                        state <= nxt;
                    else
                        cnt <= cnt - 32'd1;
                end
                CLASS: begin
                    tied_high <= r0 & r1;
                    tied_low  <= ~r0 & ~r1;
                    floating  <= ~r0 & r1;
                    anomalous <= r0 & ~r1;
                    state     <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (!act) begin
                        act <= 1'b1;
                        tmo <= '0;
                        if (is_wr) begin
                            m_axi.awaddr  <= addr;
                            m_axi.wdata   <= wdat;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            m_axi.bready  <= 1'b1;
                        end else begin
                            m_axi.araddr  <= addr;
                            m_axi.arvalid <= 1'b1;
                            m_axi.rready  <= 1'b1;
                        end
                    end else begin
                        if (aw_hs) m_axi.awvalid <= 1'b0;
                        if (w_hs)  m_axi.wvalid  <= 1'b0;
                        if (ar_hs) m_axi.arvalid <= 1'b0;
                        if (b_hs || r_hs) begin
                            m_axi.bready <= 1'b0;
                            m_axi.rready <= 1'b0;
                            act          <= 1'b0;
                            cnt          <= 32'(SETTLE_CYCLES - 1);
                            if (r_hs && state == RV0) r0 <= m_axi.rdata[WIDTH-1:0];
                            if (r_hs && state == RV1) r1 <= m_axi.rdata[WIDTH-1:0];
                            error <= error | resp_bad;
                            state <= resp_bad ? FIN : nxt;
                        end else if (phase_end) begin
                            tmo <= '0;
                        end else if (tmo == 32'(TIMEOUT_CYCLES - 1)) begin
                            m_axi.awvalid <= 1'b0;
                            m_axi.wvalid  <= 1'b0;
                            m_axi.arvalid <= 1'b0;
                            m_axi.bready  <= 1'b0;
                            m_axi.rready  <= 1'b0;
                            act           <= 1'b0;
                            error         <= 1'b1;
                            state         <= FIN;
                        end else begin
                            tmo <= tmo + 32'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_static_pin_test_sequencer.sv
// tb_static_pin_test_sequencer: AXI4-Lite slave with a pin model (vcc/gnd/keeper/inverting keeper)
// around the sequencer; expected traffic and classes come from the pin types.
module tb_static_pin_test_sequencer;
    localparam int W    = 4;
    localparam int AW   = 11;
    localparam int BASE = 'h40;
    localparam int TMO  = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, error;
    logic [W-1:0] tied_high, tied_low, floating, anomalous;
    int vectors = 0;
    int miscompares = 0;

    static_pin_test_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    static_pin_test_sequencer #(
        .WIDTH(W), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(AW),
        .BASE_ADDR(BASE), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .tied_high(tied_high), .tied_low(tied_low), .floating(floating), .anomalous(anomalous),
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    // slave configuration (written by the stimulus only)
    bit zw = 1'b1;
    bit aw_stall = 1'b0;
    int dmax = 0;
    int bad_wr = -1;
    int width_ret = W;
    int ptype [W] = '{0, 1, 2, 2};

    // slave state (written by the slave process only)
    logic [W-1:0]  drv, tri_r, kept;
    bit            aw_got, w_got, ar_got, p_awv, p_wv, p_arv, p_br, p_rr;
    bit            aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [AW-1:0] aw_a, ar_a, p_awa, p_ara;
    logic [31:0]   w_d, p_wd;
    int            aw_c, w_c, ar_c, r_c, wr_n, rd_n, aw_hi;
    logic [43:0]   trace [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pins();
        logic [W-1:0] p;
        for (int i = 0; i < W; i++)
            p[i] = (ptype[i] == 0) ? 1'b1 : (ptype[i] == 1) ? 1'b0 :
                   (ptype[i] == 2) ? kept[i] : ~kept[i];
        return p;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(dmax, 0));
    endfunction

    // Slave runs on the falling edge; handshakes are reconstructed from the values
    // held across the preceding rising edge.
    always @(negedge clk) begin
        if (reset) begin
            bus.awready = zw; bus.wready = zw; bus.arready = zw;
            bus.bvalid = 1'b0; bus.rvalid = 1'b0; bus.bresp = 2'b00; bus.rresp = 2'b00;
            bus.rdata = '0;
            drv = '0; tri_r = '1; kept = '0;
            aw_got = 0; w_got = 0; ar_got = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_br = 0; p_rr = 0;
            aw_c = rnd(); w_c = rnd(); ar_c = rnd(); r_c = 0;
            wr_n = 0; rd_n = 0; aw_hi = 0;
            trace.delete();
        end else begin
            aw_hs = p_awv && bus.awready;
            w_hs  = p_wv && bus.wready;
            ar_hs = p_arv && bus.arready;
            b_hs  = bus.bvalid && p_br;
            r_hs  = bus.rvalid && p_rr;
            if (p_awv && !aw_hs && !error) begin
                chk("awvalid_hold", bus.awvalid, 1);
                chk("awaddr_hold", bus.awaddr, p_awa);
            end
            if (p_wv && !w_hs && !error) begin
                chk("wvalid_hold", bus.wvalid, 1);
                chk("wdata_hold", bus.wdata, p_wd);
            end
            if (p_arv && !ar_hs && !error) begin
                chk("arvalid_hold", bus.arvalid, 1);
                chk("araddr_hold", bus.araddr, p_ara);
            end
            if (aw_hs) begin
                aw_got = 1; aw_a = p_awa; chk("awprot", bus.awprot, 0);
                bus.awready = zw; aw_c = rnd();
            end else if (bus.awvalid && !bus.awready && !aw_stall) begin
                if (aw_c == 0) bus.awready = 1'b1; else aw_c--;
            end
            if (w_hs) begin
                w_got = 1; w_d = p_wd; chk("wstrb", bus.wstrb, 4'hF);
                bus.wready = zw; w_c = rnd();
            end else if (bus.wvalid && !bus.wready) begin
                if (w_c == 0) bus.wready = 1'b1; else w_c--;
            end
            if (ar_hs) begin
                ar_got = 1; ar_a = p_ara; r_c = rnd(); chk("arprot", bus.arprot, 0);
                trace.push_back({1'b0, p_ara, 32'd0}); rd_n++;
                bus.arready = zw; ar_c = rnd();
            end else if (bus.arvalid && !bus.arready) begin
                if (ar_c == 0) bus.arready = 1'b1; else ar_c--;
            end
            if (b_hs) bus.bvalid = 1'b0;
            if (r_hs) bus.rvalid = 1'b0;
            if (aw_got && w_got) begin
                trace.push_back({1'b1, aw_a, w_d}); wr_n++;
                if (aw_a == AW'(BASE)) drv = w_d[W-1:0];
                if (aw_a == AW'(BASE + 4)) tri_r = w_d[W-1:0];
                bus.bresp = (wr_n == bad_wr) ? 2'b10 : 2'b00;
                bus.bvalid = 1'b1; aw_got = 0; w_got = 0;
            end
            for (int i = 0; i < W; i++) if (!tri_r[i]) kept[i] = drv[i];
            if (ar_got && !bus.rvalid) begin
                if (r_c == 0) begin
                    bus.rdata = (ar_a == AW'(BASE + 12)) ? 32'(width_ret) :
                                (ar_a == AW'(BASE + 8)) ? 32'(pins()) :
                                (ar_a == AW'(BASE + 4)) ? 32'(tri_r) : 32'(drv);
                    bus.rresp = 2'b00; bus.rvalid = 1'b1; ar_got = 0;
                end else r_c--;
            end
            if (bus.awvalid) aw_hi++;
            p_awv = bus.awvalid; p_awa = bus.awaddr; p_wv = bus.wvalid; p_wd = bus.wdata;
            p_arv = bus.arvalid; p_ara = bus.araddr; p_br = bus.bready; p_rr = bus.rready;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; tick(3); reset = 1'b0; tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int cyc = 0;
        do begin smp(); cyc++; end while (!done && cyc < lim);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    function automatic logic [43:0] ent(input bit wr, input int off, input logic [31:0] d);
        return {wr, AW'(BASE + off), d};
    endfunction

    // Expected traffic of a full error-free run, in procedure order.
    task automatic check_run(input string tag);
        logic [43:0] e [$];
        logic [W-1:0] eth, etl, efl, ean;
        e = '{ent(0, 12, 0), ent(1, 0, 0), ent(1, 4, 0), ent(1, 4, 32'hF), ent(0, 8, 0),
              ent(1, 0, 32'hF), ent(1, 4, 0), ent(1, 4, 32'hF), ent(0, 8, 0)};
        for (int i = 0; i < W; i++) begin
            eth[i] = ptype[i] == 0; etl[i] = ptype[i] == 1;
            efl[i] = ptype[i] == 2; ean[i] = ptype[i] == 3;
        end
        chk({tag, "_nlog"}, trace.size(), e.size());
        for (int i = 0; i < e.size() && i < trace.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), trace[i], e[i]);
        chk({tag, "_writes"}, wr_n, 6);
        chk({tag, "_reads"}, rd_n, 3);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_tied_high"}, tied_high, eth);
        chk({tag, "_tied_low"}, tied_low, etl);
        chk({tag, "_floating"}, floating, efl);
        chk({tag, "_anomalous"}, anomalous, ean);
        chk({tag, "_tristate_end"}, tri_r, {W{1'b1}});
    endtask

    task automatic check_idle_bus(input string tag);
        chk({tag, "_awvalid"}, bus.awvalid, 0);
        chk({tag, "_wvalid"}, bus.wvalid, 0);
        chk({tag, "_arvalid"}, bus.arvalid, 0);
        chk({tag, "_bready"}, bus.bready, 0);
        chk({tag, "_rready"}, bus.rready, 0);
    endtask

    task automatic check_vec_zero(input string tag);
        chk({tag, "_vectors"}, {tied_high, tied_low, floating, anomalous}, 0);
    endtask

    initial begin
        int n;
        #800000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset state
        do_reset();
        smp();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        check_vec_zero("rst");
        check_idle_bus("rst");

        // zero-wait slave, pins {vcc, gnd, keeper, keeper}
        tick(1);
        pulse_start();
        smp();
        chk("zw_busy", busy, 1);
        wait_done("zw", 3000);
        check_run("zw");
        tick(5); smp();
        chk("zw_hold_floating", floating, 4'b1100);
        chk("zw_hold_tied_high", tied_high, 4'b0001);

        // slave reports the wrong WIDTH
        width_ret = 3;
        do_reset();
        pulse_start();
        wait_done("wid", 3000);
        chk("wid_error", error, 1);
        chk("wid_reads", rd_n, 1);
        chk("wid_writes", wr_n, 0);
        check_vec_zero("wid");
        width_ret = W;

        // random handshake delays with random pin types
        zw = 1'b0; dmax = 20;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < W; i++) ptype[i] = int'($urandom_range(3, 0));
            do_reset();
            pulse_start();
            wait_done($sformatf("rnd%0d", r), 5000);
            check_run($sformatf("rnd%0d", r));
        end
        ptype = '{0, 1, 2, 2};

        // SLVERR on the WT0 write
        zw = 1'b1; dmax = 0; bad_wr = 2;
        do_reset();
        pulse_start();
        n = 0;
        while (wr_n < 2 && n < 500) begin smp(); n++; end
        chk("bresp_reached", wr_n, 2);
        n = 0;
        while (!done && n < 10) begin smp(); n++; end
        chk("bresp_done", done, 1);
        chk("bresp_done_lat_le2", n <= 2, 1);
        chk("bresp_error", error, 1);
        check_vec_zero("bresp");
        tick(20); smp();
        chk("bresp_no_more_beats", trace.size(), 3);
        check_idle_bus("bresp_after");
        bad_wr = -1;

        // AWREADY never rises
        zw = 1'b0; aw_stall = 1'b1;
        do_reset();
        pulse_start();
        wait_done("tmo", 3000);
        chk("tmo_awvalid_cycles", aw_hi, TMO);
        chk("tmo_error", error, 1);
        check_vec_zero("tmo");
        tick(900); smp();
        check_idle_bus("tmo_after");
        chk("tmo_writes", wr_n, 0);
        aw_stall = 1'b0; zw = 1'b1;

        // reset in SET0, clean rerun, start while busy ignored
        do_reset();
        pulse_start();
        n = 0;
        while (wr_n < 2 && n < 500) begin smp(); n++; end
        chk("rs_reached_set0", wr_n, 2);
        tick(3);
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(5); smp();
        check_idle_bus("rs_after");
        chk("rs_busy", busy, 0);
        chk("rs_no_beats", trace.size(), 0);
        tick(1);
        pulse_start();
        tick(4);
        pulse_start();
        wait_done("rs", 3000);
        check_run("rs");
        tick(30); smp();
        chk("rs_no_restart_busy", busy, 0);
        chk("rs_no_restart_log", trace.size(), 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
